sample_player: RTL and testbench
================================

Name: sample_player

Overview:
- Playback sequencer between the sample ROM (ram_c, synchronous read, 1-cycle latency) and Audio_Controller.
- Steps the ROM address once per accepted audio sample instead of once per clock.
- Formats each 24-bit sample into a 32-bit left/right word with volume attenuation.
- Drives the write strobe using the controller's audio_out_allowed handshake.
- Supports start, stop, one-shot and loop playback.

Parameters:
- ADDR_W, 14, ROM address width.
- DATA_W, 24, ROM sample width; two's complement; DATA_W <= 32.
- NUM_SAMPLES, 15000, samples in clip. Last address is NUM_SAMPLES-1. Must satisfy 1 <= NUM_SAMPLES <= 2^ADDR_W.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin playback from address 0.
- stop  in  1  one-cycle pulse; abort playback.
- loop_en  in  1  1 = wrap to address 0 after the last sample; sampled at the last write.
- vol_shift  in  2  arithmetic right shift applied to the output sample (0..3).
- ram_addr  out  ADDR_W  ROM read address.
- ram_q  in  DATA_W  ROM read data; valid the cycle after ram_addr is presented.
- audio_out_allowed  in  1  controller output FIFO has space.
- left_channel_audio_out  out  32  formatted sample.
- right_channel_audio_out  out  32  identical to left.
- write_audio_out  out  1  one-cycle write strobe to the controller.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final sample of a one-shot play.

Behaviour:
- Reset: asynchronous on resetn low. State IDLE, ram_addr=0, sample register=0, done=0. Outputs: write_audio_out=0, busy=0, both channels=0. Reset mid-playback aborts immediately; no further writes.
- States: IDLE, FETCH, LATCH, READY.
- IDLE: on start && !stop, go to FETCH with ram_addr=0. start while busy is ignored.
- FETCH: ram_addr held stable one cycle; go to LATCH.
- LATCH: capture ram_q at the end of the cycle. Sample register = ({ram_q, (32-DATA_W) zeros}) >>> vol_shift, sign-preserving. Go to READY.
- READY: write_audio_out = audio_out_allowed, combinational, so it is high for at most one cycle per sample. Stay in READY while audio_out_allowed=0. On the write cycle:
  - If ram_addr != NUM_SAMPLES-1: ram_addr+1, go to FETCH.
  - Else if loop_en: ram_addr=0, go to FETCH.
  - Else: ram_addr=0, go to IDLE, done=1 on the next cycle only.
- Channel outputs show the sample register at all times. The register is cleared to 0 on any transition into IDLE.
- vol_shift is sampled in LATCH only; a mid-sample change applies from the next sample.
- stop in any non-IDLE state: go to IDLE next edge, ram_addr=0, no done. stop in READY also suppresses write_audio_out that cycle. start and stop in the same cycle: stop wins.
- Latency: start at edge E0 gives FETCH in cycle 1, LATCH in cycle 2, READY in cycle 3. First write occurs in cycle 3 if allowed. Max throughput is one sample per 3 cycles, far above the 48 kHz codec rate.
- Single-sample clip (NUM_SAMPLES=1): every write wraps to address 0.

Test Plan:
- Reset, then start with NUM_SAMPLES=4, ROM={0x000001,0x7FFFFF,0x800000,0xFFFFFF}, allowed=1, loop_en=0, vol_shift=0 -> 4 writes in cycles 3,6,9,12. Words 0x00000100, 0x7FFFFF00, 0x80000000, 0xFFFFFF00. done pulses in cycle 13; busy=0.
- Same clip with vol_shift=2 -> words 0x00000040, 0x1FFFFFC0, 0xE0000000, 0xFFFFFFC0.
- allowed=0 for 10 cycles while in READY on sample 1 -> no strobe, ram_addr held at 1. Raising allowed gives exactly one write of 0x7FFFFF00.
- loop_en=1 across 10 writes -> addresses 0,1,2,3,0,1,2,3,0,1; done never asserts.
- stop asserted in the READY cycle of sample 2 with allowed=1 -> no write that cycle, IDLE next cycle, channels=0, ram_addr=0, done=0. A start pulse during playback has no effect.
- resetn low for 1 cycle mid-LATCH -> all outputs 0 immediately. A following start replays from address 0.

Source files
------------

// File: rtl/sample_player.sv
// Playback sequencer: steps a sync-read sample ROM once per accepted audio write and formats 32-bit L/R words.
// Latency start->first write 3 cycles; holds the sample in READY while audio_out_allowed is low.
module sample_player #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 24,
  parameter int NUM_SAMPLES = 15000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        vol_shift,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              audio_out_allowed,
  output logic [31:0]       left_channel_audio_out,
  output logic [31:0]       right_channel_audio_out,
  output logic              write_audio_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, READY} state_t;

  localparam int                PAD       = 32 - DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         sample_q, sample_d;
  logic                done_q, done_d;
  logic                wr;
  logic [31:0]         aligned;

  always_comb begin
    // Left-justify the sample so the arithmetic shift keeps the sign bit at bit 31.
    aligned  = 32'(ram_q) << PAD;
    wr       = (state_q == READY) && audio_out_allowed && !stop;
    state_d  = state_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        sample_d = $signed(aligned) >>> vol_shift;
        state_d  = READY;
      end
      READY: begin
        if (wr) begin
          if (addr_q != LAST_ADDR) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end else if (loop_en) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            addr_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      addr_d  = '0;
      done_d  = 1'b0;
    end

    if (state_d == IDLE && state_q != IDLE) sample_d = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign ram_addr                = addr_q;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign write_audio_out         = wr;
  assign busy                    = (state_q != IDLE);
  assign done                    = done_q;

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player on a 4-sample clip with a synchronous-read ROM model.
module tb_sample_player;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 24;
  localparam int NS     = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start, stop, loop_en, allowed;
  logic [1:0]        vol_shift;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic [31:0]       left_out, right_out;
  logic              wr, busy, done;

  logic [DATA_W-1:0] rom [NS];

  int n_cmp = 0;
  int n_err = 0;

  sample_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SAMPLES(NS)) dut (
    .CLOCK_50               (clk),
    .resetn                 (resetn),
    .start                  (start),
    .stop                   (stop),
    .loop_en                (loop_en),
    .vol_shift              (vol_shift),
    .ram_addr               (ram_addr),
    .ram_q                  (ram_q),
    .audio_out_allowed      (allowed),
    .left_channel_audio_out (left_out),
    .right_channel_audio_out(right_out),
    .write_audio_out        (wr),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= (ram_addr < ADDR_W'(NS)) ? rom[ram_addr[1:0]] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the start of cycle 1 (start was sampled at edge E0).
  task automatic pulse_start();
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    next_cycle();
  endtask

  task automatic play_oneshot(input string name, input logic [1:0] vs, input logic [3:0][31:0] w);
    logic exp_wr;
    vol_shift = vs;
    loop_en   = 1'b0;
    allowed   = 1'b1;
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      exp_wr = (c % 3 == 0) && (c <= 12);
      @(negedge clk);
      chk($sformatf("%s_wr_c%0d", name, c), 32'(wr), 32'(exp_wr));
      if (exp_wr) begin
        chk($sformatf("%s_left_c%0d", name, c), left_out, w[c/3-1]);
        chk($sformatf("%s_right_c%0d", name, c), right_out, w[c/3-1]);
        chk($sformatf("%s_addr_c%0d", name, c), 32'(ram_addr), 32'(c/3-1));
      end
      chk($sformatf("%s_done_c%0d", name, c), 32'(done), 32'(c == 13));
      if (c == 13) begin
        chk($sformatf("%s_busy_end", name), 32'(busy), 32'd0);
        chk($sformatf("%s_left_end", name), left_out, 32'd0);
      end
      next_cycle();
    end
  endtask

  initial begin
    logic [3:0][31:0] w_vs0, w_vs2;
    int   nwr;
    logic done_seen;

    rom[0] = 24'h000001; rom[1] = 24'h7FFFFF; rom[2] = 24'h800000; rom[3] = 24'hFFFFFF;
    w_vs0 = {32'hFFFFFF00, 32'h80000000, 32'h7FFFFF00, 32'h00000100};
    w_vs2 = {32'hFFFFFFC0, 32'hE0000000, 32'h1FFFFFC0, 32'h00000040};

    resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; allowed = 1'b1; vol_shift = 2'd0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_left", left_out, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    next_cycle();
    next_cycle();
    resetn = 1'b1;

    play_oneshot("vs0", 2'd0, w_vs0);
    play_oneshot("vs2", 2'd2, w_vs2);

    // Backpressure: allowed low for ten cycles while sample 1 waits in READY.
    vol_shift = 2'd0; loop_en = 1'b0; allowed = 1'b1;
    pulse_start();
    for (int c = 1; c <= 17; c++) begin
      allowed = (c >= 6 && c <= 15) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c >= 6 && c <= 15) begin
        chk($sformatf("bp_wr_c%0d", c), 32'(wr), 32'd0);
        chk($sformatf("bp_addr_c%0d", c), 32'(ram_addr), 32'd1);
      end
      if (c == 16) begin
        chk("bp_release_wr", 32'(wr), 32'd1);
        chk("bp_release_word", left_out, 32'h7FFFFF00);
      end
      if (c == 17) begin
        chk("bp_single_write", 32'(wr), 32'd0);
        chk("bp_addr_next", 32'(ram_addr), 32'd2);
      end
      next_cycle();
    end
    wait_idle();

    // Looping across ten writes.
    loop_en = 1'b1; allowed = 1'b1;
    nwr = 0; done_seen = 1'b0;
    pulse_start();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (wr) begin
        chk($sformatf("loop_addr_w%0d", nwr), 32'(ram_addr), 32'(nwr % 4));
        chk($sformatf("loop_cycle_w%0d", nwr), 32'(c), 32'(3 * (nwr + 1)));
        nwr++;
      end
      done_seen = done_seen | done;
      next_cycle();
    end
    chk("loop_nwrites", 32'(nwr), 32'd10);
    chk("loop_no_done", 32'(done_seen), 32'd0);
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    @(negedge clk);
    chk("loop_stop_busy", 32'(busy), 32'd0);
    next_cycle();
    loop_en = 1'b0;

    // Stop in READY of sample 2; a start pulse mid-play is ignored.
    nwr = 0;
    pulse_start();
    for (int c = 1; c <= 11; c++) begin
      start = (c == 4);
      stop  = (c == 9);
      @(negedge clk);
      if (wr) nwr++;
      if (c == 6) chk("stop_w1_addr", 32'(ram_addr), 32'd1);
      if (c == 9) begin
        chk("stop_wr_suppressed", 32'(wr), 32'd0);
        chk("stop_busy_in_ready", 32'(busy), 32'd1);
      end
      if (c == 10) begin
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_left", left_out, 32'd0);
        chk("stop_right", right_out, 32'd0);
        chk("stop_addr", 32'(ram_addr), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
      end
      if (c == 11) chk("stop_done_after", 32'(done), 32'd0);
      next_cycle();
    end
    start = 1'b0; stop = 1'b0;
    chk("stop_nwrites", 32'(nwr), 32'd2);

    start = 1'b1; stop = 1'b1;
    next_cycle();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_stop_same", 32'(busy), 32'd0);
    next_cycle();

    // Reset pulse during LATCH of sample 1, then a clean replay.
    pulse_start();
    for (int c = 1; c < 5; c++) next_cycle();
    chk("prerst_left", left_out, 32'h00000100);
    chk("prerst_addr", 32'(ram_addr), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(ram_addr), 32'd0);
    chk("midrst_left", left_out, 32'd0);
    chk("midrst_right", right_out, 32'd0);
    chk("midrst_wr", 32'(wr), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    next_cycle();
    resetn = 1'b1;
    play_oneshot("replay", 2'd0, w_vs0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
